fir_filter_ctrl: RTL

//  Sequencer for fir_filter_calc (single-tap RGB multiplier). Holds NUM_TAPS kernel coefficients.
//  For each output pixel, steps through the taps: loads coefficient, feeds one input pixel, and

---
 rtl/fir_filter_pkg.sv | 21 ++
 rtl/fir_coef_rf.sv | 30 +++
 rtl/fir_filter_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_filter_pkg.sv
// Shared types and helpers for the FIR sequencer: state encoding, widths, output clamp.
package fir_filter_pkg;
  localparam int PIX_W   = 24;
  localparam int PROD_W  = 17;
  localparam int CLAMP_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TC,
    ST_MAC,
    ST_ACC,
    ST_OUT,
    ST_FIN
  } state_e;

  function automatic logic [7:0] clamp_u8(input logic signed [CLAMP_W-1:0] v);
    if (v < 0)        return 8'd0;
    else if (v > 255) return 8'hFF;
    else              return v[7:0];
  endfunction
endpackage

// File: rtl/fir_coef_rf.sv
// Kernel coefficient store: one {r,g,b} signed-byte triple per tap.
// Sync write, async read, cleared by reset.
module fir_coef_rf
  import fir_filter_pkg::*;
#(
  parameter int NUM_TAPS = 9,
  parameter int TAP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [TAP_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [TAP_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [NUM_TAPS-1:0][PIX_W-1:0] mem_q, mem_d;

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++)
      mem_d[i] = (we && waddr == TAP_W'(i)) ? wdata : mem_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fir_filter_ctrl.sv
// Tap sequencer for the single-tap RGB multiplier: loads a coefficient, feeds a pixel,
// accumulates the held product, and emits a shifted/clamped pixel per NUM_TAPS taps.
module fir_filter_ctrl
  import fir_filter_pkg::*;
#(
  parameter int NUM_TAPS = 9,
  parameter int ACC_W    = 21,
  parameter int SHIFT    = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [23:0]       coef_data,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_out,
  output logic              busy,
  output logic              done,
  input  logic              pix_valid,
  input  logic [23:0]       pix_data,
  output logic              pix_ready,
  output logic [23:0]       io_data,
  output logic [23:0]       tc_data,
  output logic              tc_write,
  output logic              tc_en,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic [16:0]       filter_r,
  input  logic [16:0]       filter_g,
  input  logic [16:0]       filter_b,
  output logic              out_valid,
  output logic [23:0]       out_data,
  input  logic              out_ready
);
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  state_e                    state_q, state_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [2:0][ACC_W-1:0]     acc_q, acc_d;   // [2]=r [1]=g [0]=b
  logic [2:0][PROD_W-1:0]    prod;
  logic [2:0][7:0]           clamped;
  logic [PIX_W-1:0]          coef_rd;
  logic                      coef_we;

  assign prod    = {filter_r, filter_g, filter_b};
  // Writes only land while idle, so a write issued with start is visible to the first TC.
  assign coef_we = (state_q == ST_IDLE) && coef_wr && (32'(coef_addr) < NUM_TAPS);

  fir_coef_rf #(.NUM_TAPS(NUM_TAPS), .TAP_W(TAP_W)) u_coef_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_we),
    .waddr (coef_addr[TAP_W-1:0]),
    .wdata (coef_data),
    .raddr (tap_q),
    .rdata (coef_rd)
  );

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [ACC_W-1:0] sh;
    assign sh         = $signed(acc_q[c]) >>> SHIFT;
    assign clamped[c] = clamp_u8({{(CLAMP_W-ACC_W){sh[ACC_W-1]}}, sh});
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    count_d   = count_q;
    acc_d     = acc_q;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    pix_ready = 1'b0;
    io_data   = '0;
    tc_data   = '0;
    tc_write  = 1'b0;
    tc_en     = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        count_d = num_out;
        tap_d   = '0;
        acc_d   = '0;
        state_d = (num_out == '0) ? ST_FIN : ST_TC;
      end
      ST_TC: begin
        tc_data  = coef_rd;
        tc_write = 1'b1;
        tc_en    = 1'b1;
        mac_clr  = (tap_q == '0);
        state_d  = ST_MAC;
      end
      ST_MAC: begin
        pix_ready = pix_valid;
        if (pix_valid) begin
          io_data = pix_data;
          mac_en  = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        for (int c = 0; c < 3; c++)
          acc_d[c] = acc_q[c] + {{(ACC_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]};
        if (tap_q == TAP_W'(NUM_TAPS-1)) state_d = ST_OUT;
        else begin
          tap_d   = tap_q + TAP_W'(1);
          state_d = ST_TC;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_data  = {clamped[2], clamped[1], clamped[0]};
        if (out_ready) begin
          count_d = count_q - CNT_W'(1);
          acc_d   = '0;
          tap_d   = '0;
          state_d = (count_q == CNT_W'(1)) ? ST_FIN : ST_TC;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end
endmodule
